// File: rtl/umi_req_split_if.sv
// Descriptor-in / packet-descriptor-out bundle for umi_req_split.
// master = upstream/downstream environment view, slave = splitter view.
interface umi_req_split_if #(
  parameter int AW = 64
) ();
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_opcode;
  logic [2:0]    in_size;
  logic [15:0]   in_len;
  logic [3:0]    in_qos;
  logic [1:0]    in_prot;
  logic [4:0]    in_hostid;
  logic [AW-1:0] in_dstaddr;
  logic [AW-1:0] in_srcaddr;

  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_opcode;
  logic [2:0]    out_size;
  logic [7:0]    out_len;
  logic          out_eom;
  logic [3:0]    out_qos;
  logic [1:0]    out_prot;
  logic [4:0]    out_hostid;
  logic [AW-1:0] out_dstaddr;
  logic [AW-1:0] out_srcaddr;

  modport master (
    output in_valid, in_opcode, in_size, in_len, in_qos, in_prot, in_hostid,
           in_dstaddr, in_srcaddr, out_ready,
    input  in_ready, out_valid, out_opcode, out_size, out_len, out_eom,
           out_qos, out_prot, out_hostid, out_dstaddr, out_srcaddr
  );

  modport slave (
    input  in_valid, in_opcode, in_size, in_len, in_qos, in_prot, in_hostid,
           in_dstaddr, in_srcaddr, out_ready,
    output in_ready, out_valid, out_opcode, out_size, out_len, out_eom,
           out_qos, out_prot, out_hostid, out_dstaddr, out_srcaddr
  );
endinterface

// File: rtl/umi_req_split.sv
// Splits one UMI transaction descriptor (16-bit word count) into packet
// descriptors of at most one bus-width each, feeding the command packer.
module umi_req_split #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
) (
  input  logic             clk,
  input  logic             nreset,
  umi_req_split_if.slave   req,
  output logic             busy
);

  localparam int BYTES = DW / 8;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  if (DW < 8 || DW > 2048 || (DW & (DW - 1)) != 0 || CW < 1) begin : g_bad_param
    $error("umi_req_split: DW must be a power of two in 8..2048 and CW >= 1");
  end

  logic [0:0]    state;
  logic [4:0]    opcode_q;
  logic [2:0]    size_q;
  logic [3:0]    qos_q;
  logic [1:0]    prot_q;
  logic [4:0]    hostid_q;
  logic [16:0]   remaining;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] src_q;

  logic [11:0]   shifted;
  logic [8:0]    maxwords;
  logic [8:0]    pkt_words;
  logic          last_pkt;
  logic [AW-1:0] step;

  // Words per packet: one bus beat, but never zero when a word is wider than the bus.
  always_comb begin
    shifted   = 12'(BYTES) >> size_q;
    maxwords  = (shifted == 12'd0)   ? 9'd1   :
                (shifted > 12'd256)  ? 9'd256 : shifted[8:0];
    last_pkt  = (remaining <= {8'd0, maxwords});
    pkt_words = last_pkt ? remaining[8:0] : maxwords;
    step      = AW'(pkt_words) << size_q;
  end

  assign busy         = (state == BUSY);
  assign req.in_ready = (state == IDLE);

  // Gated by busy so the idle/reset view shows zeros rather than len=0xFF.
  assign req.out_valid   = busy;
  assign req.out_len     = busy ? 8'(pkt_words - 9'd1) : 8'd0;
  assign req.out_eom     = busy & last_pkt;
  assign req.out_opcode  = opcode_q;
  assign req.out_size    = size_q;
  assign req.out_qos     = qos_q;
  assign req.out_prot    = prot_q;
  assign req.out_hostid  = hostid_q;
  assign req.out_dstaddr = dst_q;
  assign req.out_srcaddr = src_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      opcode_q  <= '0;
      size_q    <= '0;
      qos_q     <= '0;
      prot_q    <= '0;
      hostid_q  <= '0;
      remaining <= '0;
      dst_q     <= '0;
      src_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req.in_valid) begin
            state     <= BUSY;
            opcode_q  <= req.in_opcode;
            size_q    <= req.in_size;
            qos_q     <= req.in_qos;
            prot_q    <= req.in_prot;
            hostid_q  <= req.in_hostid;
            remaining <= {1'b0, req.in_len} + 17'd1;
            dst_q     <= req.in_dstaddr;
            src_q     <= req.in_srcaddr;
          end
        end
        default: begin
          if (req.out_ready) begin
            if (last_pkt) begin
              state <= IDLE;
            end else begin
              remaining <= remaining - {8'd0, pkt_words};
              dst_q     <= dst_q + step;
              src_q     <= src_q + step;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_umi_req_split.sv
// Randomized scoreboard bench for umi_req_split (DW=256): a reference model
// expands each descriptor into expected packets; a monitor pops and compares.
module tb_umi_req_split;

  logic clk = 1'b0;
  logic nreset;
  logic busy;
  always #5 clk = ~clk;

  umi_req_split_if #(.AW(64)) bus ();

  umi_req_split #(.CW(32), .AW(64), .DW(256)) dut (
    .clk    (clk),
    .nreset (nreset),
    .req    (bus),
    .busy   (busy)
  );

  typedef struct packed {
    logic [7:0]  len;
    logic        eom;
    logic [63:0] dst;
    logic [63:0] src;
    logic [4:0]  op;
    logic [2:0]  sz;
    logic [3:0]  qos;
    logic [1:0]  prot;
    logic [4:0]  hid;
  } pkt_t;

  pkt_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          hs_cnt = 0;
  logic [63:0] last_dst = '0;
  bit          stall_en = 1'b0;
  bit          ready_val = 1'b1;

  task automatic chk(input string nm, input bit ok, input string det);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: %s", nm, det);
    end
  endtask

  // Reference: a packet carries one 32-byte beat worth of words (at least one word).
  task automatic model_push(input logic [4:0] op, input logic [2:0] sz, input int len,
                            input logic [3:0] qos, input logic [1:0] prot, input logic [4:0] hid,
                            input logic [63:0] dst, input logic [63:0] src);
    int bpw, wpp, left, n;
    pkt_t p;
    bpw  = 1 << sz;
    wpp  = (bpw >= 32) ? 1 : 32 / bpw;
    left = len + 1;
    while (left > 0) begin
      n = (left < wpp) ? left : wpp;
      p = '{len: 8'(n - 1), eom: (left == n), dst: dst, src: src,
            op: op, sz: sz, qos: qos, prot: prot, hid: hid};
      q.push_back(p);
      dst  = dst + 64'(n * bpw);
      src  = src + 64'(n * bpw);
      left = left - n;
    end
  endtask

  always begin
    @(posedge clk);
    #1 bus.out_ready = stall_en ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Monitor: compares on every handshake, checks hold-stability under stall.
  pkt_t held, cur, exp_p;
  bit   prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!nreset) begin
      prev_stall = 1'b0;
    end else if (bus.out_valid) begin
      cur = '{len: bus.out_len, eom: bus.out_eom, dst: bus.out_dstaddr, src: bus.out_srcaddr,
              op: bus.out_opcode, sz: bus.out_size, qos: bus.out_qos, prot: bus.out_prot,
              hid: bus.out_hostid};
      if (prev_stall)
        chk("stall_hold", cur == held, $sformatf("got %h want %h", cur, held));
      chk("in_ready_busy", bus.in_ready == 1'b0, $sformatf("in_ready=%0b want 0", bus.in_ready));
      if (bus.out_ready) begin
        hs_cnt++;
        last_dst = cur.dst;
        prev_stall = 1'b0;
        if (q.size() == 0) begin
          chk("unexpected_pkt", 1'b0, $sformatf("got %h want none", cur));
        end else begin
          exp_p = q.pop_front();
          chk("pkt", cur == exp_p,
              $sformatf("got len=%0d eom=%0b dst=%h src=%h op=%0d sz=%0d q=%0d p=%0d h=%0d want len=%0d eom=%0b dst=%h src=%h op=%0d sz=%0d q=%0d p=%0d h=%0d",
                        cur.len, cur.eom, cur.dst, cur.src, cur.op, cur.sz, cur.qos, cur.prot, cur.hid,
                        exp_p.len, exp_p.eom, exp_p.dst, exp_p.src, exp_p.op, exp_p.sz, exp_p.qos, exp_p.prot, exp_p.hid));
        end
      end else begin
        held = cur;
        prev_stall = 1'b1;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [2:0] sz, input int len, input logic [63:0] dst, input logic [63:0] src);
    int n = 0;
    logic [4:0] op;
    logic [3:0] qos;
    logic [1:0] prot;
    logic [4:0] hid;
    op = 5'($urandom); qos = 4'($urandom); prot = 2'($urandom); hid = 5'($urandom);
    @(negedge clk);
    while (!bus.in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 1'b0, "in_ready=0 want 1");
    end else begin
      bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_size = sz; bus.in_len = 16'(len);
      bus.in_qos = qos; bus.in_prot = prot; bus.in_hostid = hid;
      bus.in_dstaddr = dst; bus.in_srcaddr = src;
      model_push(op, sz, len, qos, prot, hid, dst, src);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_opcode = 5'($urandom); bus.in_size = 3'($urandom); bus.in_len = 16'($urandom);
      bus.in_dstaddr = {$urandom, $urandom}; bus.in_srcaddr = {$urandom, $urandom};
      @(negedge clk);
      chk("first_latency", bus.out_valid == 1'b1, $sformatf("out_valid=%0b want 1", bus.out_valid));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size() == 0, $sformatf("%0d pkts left want 0", q.size()));
    @(posedge clk);
    #1;
    chk("idle_after", !bus.out_valid && !busy && bus.in_ready,
        $sformatf("valid=%0b busy=%0b in_ready=%0b want 0,0,1", bus.out_valid, busy, bus.in_ready));
  endtask

  task automatic expect_zero_outputs(input string nm);
    chk(nm, bus.out_valid == 0 && bus.out_len == 0 && bus.out_eom == 0 && bus.out_dstaddr == 0 &&
            bus.out_srcaddr == 0 && bus.out_opcode == 0 && bus.out_size == 0 && busy == 0 &&
            bus.in_ready == 1,
        $sformatf("valid=%0b len=%0d eom=%0b dst=%h src=%h op=%0d busy=%0b in_ready=%0b want all 0, in_ready 1",
                  bus.out_valid, bus.out_len, bus.out_eom, bus.out_dstaddr, bus.out_srcaddr,
                  bus.out_opcode, busy, bus.in_ready));
  endtask

  initial begin
    int base, n;
    nreset = 1'b0;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_size = '0; bus.in_len = '0;
    bus.in_qos = '0; bus.in_prot = '0; bus.in_hostid = '0;
    bus.in_dstaddr = '0; bus.in_srcaddr = '0; bus.out_ready = 1'b0;
    #12;
    expect_zero_outputs("reset_state");
    @(posedge clk);
    #2 nreset = 1'b1;

    // 20 words of 4B -> 8,8,4
    base = hs_cnt;
    send(3'd2, 19, 64'h1000, 64'h8000);
    drain();
    chk("basic_count", hs_cnt - base == 3, $sformatf("got %0d want 3", hs_cnt - base));

    // word wider than bus -> one word per packet
    base = hs_cnt;
    send(3'd6, 2, 64'h0, 64'h100);
    drain();
    chk("wide_count", hs_cnt - base == 3, $sformatf("got %0d want 3", hs_cnt - base));

    base = hs_cnt;
    send(3'd0, 0, 64'h33, 64'h44);
    drain();
    chk("single_count", hs_cnt - base == 1, $sformatf("got %0d want 1", hs_cnt - base));

    base = hs_cnt;
    send(3'd0, 16'hFFFF, 64'h2000, 64'h9000);
    drain();
    chk("max_count", hs_cnt - base == 2048, $sformatf("got %0d want 2048", hs_cnt - base));
    chk("max_last_dst", last_dst == 64'h2000 + 64'hFFE0, $sformatf("got %h want %h", last_dst, 64'h2000 + 64'hFFE0));

    base = hs_cnt;
    send(3'd3, 7, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10);
    drain();
    chk("wrap_count", hs_cnt - base == 2, $sformatf("got %0d want 2", hs_cnt - base));
    chk("wrap_dst", last_dst == 64'h10, $sformatf("got %h want 10", last_dst));

    // 5-packet transfer under random backpressure
    stall_en = 1'b1;
    base = hs_cnt;
    send(3'd2, 39, 64'hA000, 64'hB000);
    drain();
    chk("stall_count", hs_cnt - base == 5, $sformatf("got %0d want 5", hs_cnt - base));

    for (int i = 0; i < 25; i++)
      send(3'($urandom_range(0, 7)), int'($urandom_range(0, 150)), {$urandom, $urandom}, {$urandom, $urandom});
    drain();

    // reset while the 2nd of 3 packets is stalled
    stall_en = 1'b0;
    ready_val = 1'b1;
    base = hs_cnt;
    send(3'd2, 23, 64'h5000, 64'h6000);
    n = 0;
    while (hs_cnt < base + 1 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("reset_reach_pkt2", hs_cnt == base + 1, $sformatf("handshakes %0d want 1", hs_cnt - base));
    ready_val = 1'b0;
    bus.out_ready = 1'b0;
    #1 nreset = 1'b0;
    #1;
    expect_zero_outputs("reset_abort");
    q.delete();
    @(posedge clk);
    #2 nreset = 1'b1;
    ready_val = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", bus.in_ready == 1'b1, $sformatf("in_ready=%0b want 1", bus.in_ready));
    base = hs_cnt;
    send(3'd1, 5, 64'h7000, 64'h7100);
    drain();
    chk("post_reset_count", hs_cnt - base == 1, $sformatf("got %0d want 1", hs_cnt - base));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    fails++;
    $display("FAIL global_timeout: sim time exceeded, want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
